controller_sequencer: RTL and testbench
=======================================

CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: opcode  input  4  instruction opcode from IR upper nibble; used only in T4-T6.
REQ-005 Port: t_state  output  6  one-hot ring state, bit0=T1 ... bit5=T6.
REQ-006 Port: halt  output  1  sticky halted flag.
REQ-007 Port: pc_inc  output  1  program counter increment.
REQ-008 Port: pc_enable  output  1  PC drives w_bus.
REQ-009 Port: mar_load  output  1  MAR loads from w_bus.
REQ-010 Port: ram_enable  output  1  RAM drives w_bus.
REQ-011 Port: ir_load  output  1  IR loads from w_bus.
REQ-012 Port: ir_enable  output  1  IR operand nibble drives w_bus.
REQ-013 Port: a_load  output  1  accumulator loads from w_bus.
REQ-014 Port: a_enable  output  1  accumulator drives w_bus.
REQ-015 Port: alu_sub  output  1  ALU sub select.
REQ-016 Port: alu_enable  output  1  ALU result drives w_bus.
REQ-017 Port: b_load  output  1  B register loads from w_bus.
REQ-018 Port: out_load  output  1  output register loads from w_bus.
REQ-019 Opcode constants: LDA=4'b0000, ADD=4'b0001, SUB=4'b0010, OUT=4'b1110, HLT=4'b1111; all others undefined (NOP).

Function
REQ-020 Ring counter SHALL advance T1->T2->T3->T4->T5->T6->T1 each rising edge while not halted.
REQ-021 All control outputs SHALL be combinational decode of t_state and opcode; all control outputs active-high, all 0 unless listed.
REQ-022 T1: pc_enable=1, mar_load=1.
REQ-023 T2: pc_inc=1.
REQ-024 T3: ram_enable=1, ir_load=1.
REQ-025 T4: LDA/ADD/SUB -> ir_enable=1, mar_load=1; OUT -> a_enable=1, out_load=1; HLT/undefined -> none.
REQ-026 T5: LDA -> ram_enable=1, a_load=1; ADD/SUB -> ram_enable=1, b_load=1; others -> none.
REQ-027 T6: ADD -> alu_enable=1, a_load=1, alu_sub=0; SUB -> alu_enable=1, a_load=1, alu_sub=1; others -> none.
REQ-028 On the rising edge in T4 with opcode=HLT, halt SHALL go 1 and t_state SHALL go 6'b000000.
REQ-029 While halt=1: t_state held at 0, all control outputs 0, opcode ignored, until rst.
REQ-030 At most one of pc_enable, ram_enable, ir_enable, a_enable, alu_enable SHALL be 1 in any cycle.
REQ-031 When not halted, t_state SHALL be exactly one-hot.
REQ-032 Undefined opcodes SHALL complete a full 6-cycle instruction with no T4-T6 controls asserted.
REQ-033 opcode changes during T1-T3 SHALL have no effect on outputs.

Reset
REQ-034 rst=1 at rising edge SHALL force t_state=6'b000001, halt=0, regardless of state or halt.
REQ-035 rst SHALL take priority over halt setting and ring advance in the same edge.
REQ-036 rst asserted mid-instruction (any T) SHALL abandon the instruction; first cycle after release is T1.
REQ-037 While rst held high, t_state SHALL remain T1 and T1 controls SHALL be driven.

Verification
REQ-038 rst=1 for 2 cycles, release -> t_state=000001, pc_enable=1, mar_load=1; next cycle t_state=000010, pc_inc=1 only.
REQ-039 opcode=ADD, run 6 cycles -> T4 ir_enable,mar_load; T5 ram_enable,b_load; T6 alu_enable=1,a_load=1,alu_sub=0; then t_state=000001.
REQ-040 opcode=SUB -> T6 alu_enable=1, a_load=1, alu_sub=1; opcode=LDA -> T5 ram_enable=1, a_load=1, T6 no controls.
REQ-041 opcode=HLT -> T4 all controls 0; next edge halt=1, t_state=000000, held 10 cycles; rst -> halt=0, t_state=000001.
REQ-042 opcode=LDA, rst pulsed during T5 -> next cycle t_state=000001, a_load=0.
REQ-043 Random opcodes incl. 4'b0101, 1000 cycles -> one-hot (REQ-031) and single bus driver (REQ-030) hold every cycle.

Source files
------------

// File: rtl/controller_sequencer.sv
// controller_sequencer
//   Six-phase (T1..T6) instruction sequencer for a simple accumulator machine.
//   A one-hot ring counter steps through fetch (T1-T3) and execute (T4-T6);
//   every control line is a combinational decode of the ring state and the
//   opcode. HLT seen in T4 parks the ring at all-zeros until reset.
//
// Ports
//   clk        in   system clock, rising-edge active
//   rst        in   synchronous active-high reset (forces T1, clears halt)
//   opcode     in   [3:0] IR upper nibble, decoded only in T4-T6
//   t_state    out  [5:0] one-hot ring, bit0=T1 ... bit5=T6, 0 when halted
//   halt       out  sticky halted flag
//   pc_inc .. out_load  out  active-high datapath controls

module controller_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       halt,
    output logic       pc_inc,
    output logic       pc_enable,
    output logic       mar_load,
    output logic       ram_enable,
    output logic       ir_load,
    output logic       ir_enable,
    output logic       a_load,
    output logic       a_enable,
    output logic       alu_sub,
    output logic       alu_enable,
    output logic       b_load,
    output logic       out_load
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Encodings are the ring bits themselves, so t_state is the state
    // register and the halted state is simply the empty ring.
    typedef enum logic [5:0] {
        S_HALT = 6'b000000,
        S_T1   = 6'b000001,
        S_T2   = 6'b000010,
        S_T3   = 6'b000100,
        S_T4   = 6'b001000,
        S_T5   = 6'b010000,
        S_T6   = 6'b100000
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_T1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = (opcode == OP_HLT) ? S_HALT : S_T5;
            S_T5:    state_d = S_T6;
            S_T6:    state_d = S_T1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_T1;
        endcase
    end

    assign t_state = state_q;
    assign halt    = (state_q == S_HALT);

    always_comb begin
        pc_inc     = 1'b0;
        pc_enable  = 1'b0;
        mar_load   = 1'b0;
        ram_enable = 1'b0;
        ir_load    = 1'b0;
        ir_enable  = 1'b0;
        a_load     = 1'b0;
        a_enable   = 1'b0;
        alu_sub    = 1'b0;
        alu_enable = 1'b0;
        b_load     = 1'b0;
        out_load   = 1'b0;
        case (state_q)
            S_T1: begin
                pc_enable = 1'b1;
                mar_load  = 1'b1;
            end
            S_T2: begin
                pc_inc = 1'b1;
            end
            S_T3: begin
                ram_enable = 1'b1;
                ir_load    = 1'b1;
            end
            S_T4: begin
                if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                    ir_enable = 1'b1;
                    mar_load  = 1'b1;
                end else if (opcode == OP_OUT) begin
                    a_enable = 1'b1;
                    out_load = 1'b1;
                end
            end
            S_T5: begin
                if (opcode == OP_LDA) begin
                    ram_enable = 1'b1;
                    a_load     = 1'b1;
                end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ram_enable = 1'b1;
                    b_load     = 1'b1;
                end
            end
            S_T6: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    alu_enable = 1'b1;
                    a_load     = 1'b1;
                    alu_sub    = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_controller_sequencer.sv
// Testbench for controller_sequencer: a directed vector table, hand-written
// reset/halt corner sequences, and a randomized run against a phase-counter
// reference model with one-hot and single-bus-driver checks.

module tb_controller_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       halt;
    logic       pc_inc, pc_enable, mar_load, ram_enable, ir_load, ir_enable;
    logic       a_load, a_enable, alu_sub, alu_enable, b_load, out_load;

    controller_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .t_state    (t_state),
        .halt       (halt),
        .pc_inc     (pc_inc),
        .pc_enable  (pc_enable),
        .mar_load   (mar_load),
        .ram_enable (ram_enable),
        .ir_load    (ir_load),
        .ir_enable  (ir_enable),
        .a_load     (a_load),
        .a_enable   (a_enable),
        .alu_sub    (alu_sub),
        .alu_enable (alu_enable),
        .b_load     (b_load),
        .out_load   (out_load)
    );

    always #5 clk = ~clk;

    // Control vector bit positions.
    localparam int unsigned B_PCI = 11, B_PCE = 10, B_MAR = 9, B_RAM = 8;
    localparam int unsigned B_IRL = 7, B_IRE = 6, B_AL = 5, B_AE = 4;
    localparam int unsigned B_SUB = 3, B_ALU = 2, B_BL = 1, B_OUT = 0;

    localparam logic [11:0] C_NONE = 12'h000;
    localparam logic [11:0] C_T1   = (12'd1 << B_PCE) | (12'd1 << B_MAR);
    localparam logic [11:0] C_T2   = (12'd1 << B_PCI);
    localparam logic [11:0] C_T3   = (12'd1 << B_RAM) | (12'd1 << B_IRL);
    localparam logic [11:0] C_FOP  = (12'd1 << B_IRE) | (12'd1 << B_MAR);
    localparam logic [11:0] C_OUT4 = (12'd1 << B_AE)  | (12'd1 << B_OUT);
    localparam logic [11:0] C_LDA5 = (12'd1 << B_RAM) | (12'd1 << B_AL);
    localparam logic [11:0] C_AB5  = (12'd1 << B_RAM) | (12'd1 << B_BL);
    localparam logic [11:0] C_ADD6 = (12'd1 << B_ALU) | (12'd1 << B_AL);
    localparam logic [11:0] C_SUB6 = (12'd1 << B_ALU) | (12'd1 << B_AL) | (12'd1 << B_SUB);

    logic [11:0] ctrl;
    assign ctrl = {pc_inc, pc_enable, mar_load, ram_enable, ir_load, ir_enable,
                   a_load, a_enable, alu_sub, alu_enable, b_load, out_load};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [5:0]  ts;
        logic        hlt;
        logic [11:0] ctrl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] op, input logic [5:0] ts,
                                input logic hlt, input logic [11:0] c);
        vec_t v;
        v.op = op; v.ts = ts; v.hlt = hlt; v.ctrl = c;
        return v;
    endfunction

    // One full instruction; fetch cycles carry an unrelated opcode to show
    // it is ignored before T4.
    task automatic add_instr(input logic [3:0] op, input logic [3:0] early,
                             input logic [11:0] c4, input logic [11:0] c5,
                             input logic [11:0] c6);
        vecs.push_back(mk(early, 6'b000001, 1'b0, C_T1));
        vecs.push_back(mk(early, 6'b000010, 1'b0, C_T2));
        vecs.push_back(mk(early, 6'b000100, 1'b0, C_T3));
        vecs.push_back(mk(op,    6'b001000, 1'b0, c4));
        vecs.push_back(mk(op,    6'b010000, 1'b0, c5));
        vecs.push_back(mk(op,    6'b100000, 1'b0, c6));
    endtask

    // Reference: expected controls from the instruction phase (0..5) and
    // opcode, written as what each instruction does in each step.
    function automatic logic [11:0] model_ctrl(input int phase, input logic [3:0] op);
        bit is_lda, is_add, is_sub, is_out;
        is_lda = (op == 4'd0);
        is_add = (op == 4'd1);
        is_sub = (op == 4'd2);
        is_out = (op == 4'd14);
        case (phase)
            0: return C_T1;
            1: return C_T2;
            2: return C_T3;
            3: return (is_lda || is_add || is_sub) ? C_FOP : (is_out ? C_OUT4 : C_NONE);
            4: return is_lda ? C_LDA5 : ((is_add || is_sub) ? C_AB5 : C_NONE);
            5: return is_add ? C_ADD6 : (is_sub ? C_SUB6 : C_NONE);
            default: return C_NONE;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 4'd0;

        // Reset for two cycles, then release.
        do_reset();
        chk("rst_tstate", 32'(t_state), 32'h01);
        chk("rst_halt",   32'(halt),    32'h0);
        chk("rst_ctrl",   32'(ctrl),    32'(C_T1));

        // Directed table, applied back to back from T1.
        add_instr(4'd1,  4'd15, C_FOP,  C_AB5,  C_ADD6);  // ADD
        add_instr(4'd2,  4'd1,  C_FOP,  C_AB5,  C_SUB6);  // SUB
        add_instr(4'd0,  4'd2,  C_FOP,  C_LDA5, C_NONE);  // LDA
        add_instr(4'd14, 4'd0,  C_OUT4, C_NONE, C_NONE);  // OUT
        add_instr(4'd5,  4'd14, C_NONE, C_NONE, C_NONE);  // undefined
        vecs.push_back(mk(4'd3,  6'b000001, 1'b0, C_T1));
        vecs.push_back(mk(4'd3,  6'b000010, 1'b0, C_T2));
        vecs.push_back(mk(4'd3,  6'b000100, 1'b0, C_T3));
        vecs.push_back(mk(4'd15, 6'b001000, 1'b0, C_NONE)); // HLT in T4
        vecs.push_back(mk(4'd1,  6'b000000, 1'b1, C_NONE));
        vecs.push_back(mk(4'd2,  6'b000000, 1'b1, C_NONE));

        for (int i = 0; i < vecs.size(); i++) begin
            opcode = vecs[i].op;
            #1;
            chk($sformatf("vec%0d_tstate", i), 32'(t_state), 32'(vecs[i].ts));
            chk($sformatf("vec%0d_halt", i),   32'(halt),    32'(vecs[i].hlt));
            chk($sformatf("vec%0d_ctrl", i),   32'(ctrl),    32'(vecs[i].ctrl));
            tick();
        end

        // Halt holds for 10 more cycles whatever the opcode.
        for (int i = 0; i < 10; i++) begin
            opcode = 4'($urandom);
            #1;
            chk("halt_hold_tstate", 32'(t_state), 32'h00);
            chk("halt_hold_halt",   32'(halt),    32'h1);
            chk("halt_hold_ctrl",   32'(ctrl),    32'(C_NONE));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("halt_rst_tstate", 32'(t_state), 32'h01);
        chk("halt_rst_halt",   32'(halt),    32'h0);

        // Reset during LDA T5 abandons the load.
        do_reset();
        opcode = 4'd0;
        repeat (4) tick();
        chk("lda_t5_ctrl", 32'(ctrl), 32'(C_LDA5));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("lda_rst_tstate", 32'(t_state), 32'h01);
        chk("lda_rst_aload",  32'(a_load),  32'h0);
        chk("lda_rst_ctrl",   32'(ctrl),    32'(C_T1));

        // Reset wins over HLT at the T4 edge.
        do_reset();
        opcode = 4'd15;
        repeat (3) tick();
        chk("hlt_t4_tstate", 32'(t_state), 32'h08);
        rst = 1'b1;
        tick();
        chk("hlt_vs_rst_tstate", 32'(t_state), 32'h01);
        chk("hlt_vs_rst_halt",   32'(halt),    32'h0);
        chk("rst_held_ctrl",     32'(ctrl),    32'(C_T1));
        tick();
        chk("rst_held_tstate",   32'(t_state), 32'h01);
        rst = 1'b0;

        // Randomized run against the phase model.
        begin
            int  phase;
            bit  halted;
            bit  r;
            int  drivers;
            logic [3:0] op;
            do_reset();
            phase  = 0;
            halted = 1'b0;
            for (int cyc = 0; cyc < 1000; cyc++) begin
                op = 4'($urandom);
                if ($urandom_range(2) == 0) op = 4'b0101;
                r  = halted ? ($urandom_range(3) == 0) : ($urandom_range(49) == 0);
                opcode = op;
                rst    = r;
                #1;
                chk("rnd_halt", 32'(halt), 32'(halted));
                chk("rnd_tstate", 32'(t_state), halted ? 32'h0 : (32'h1 << phase));
                chk("rnd_ctrl", 32'(ctrl), halted ? 32'(C_NONE) : 32'(model_ctrl(phase, op)));
                if (!halt) chk("rnd_onehot", 32'($countones(t_state)), 32'd1);
                drivers = int'(pc_enable) + int'(ram_enable) + int'(ir_enable) +
                          int'(a_enable) + int'(alu_enable);
                chk("rnd_bus_ok", 32'(drivers <= 1), 32'd1);
                tick();
                if (r) begin
                    phase  = 0;
                    halted = 1'b0;
                end else if (!halted) begin
                    if (phase == 3 && op == 4'd15) halted = 1'b1;
                    else phase = (phase + 1) % 6;
                end
            end
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
